// File: rtl/router_pkg.sv
// Shared types, constants and port-select helpers for the router ingress controller.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int TIMEOUT_DEFAULT = 30;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DA,
    WTE,
    LFD,
    LD,
    LP,
    CPE,
    DROP
  } state_t;

  // Pick the flag of the addressed port; the invalid address reads as 0.
  function automatic logic bit_at(input logic [2:0] vec, input logic [1:0] addr);
    case (addr)
      2'd0:    return vec[0];
      2'd1:    return vec[1];
      2'd2:    return vec[2];
      default: return 1'b0;
    endcase
  endfunction

  // One-hot write select for the addressed port; the invalid address selects nothing.
  function automatic logic [2:0] port_onehot(input logic [1:0] addr);
    case (addr)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/router_sreset_timer.sv
// Per-FIFO read timeout: counts cycles a non-empty FIFO goes unread and
// emits a one-cycle soft_reset pulse when the destination has stalled too long.
module router_sreset_timer #(
  parameter int TIMEOUT = router_pkg::TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic read_enb,
  input  logic fifo_empty,
  output logic soft_reset
);

  localparam logic [4:0] LAST = 5'(TIMEOUT - 1);

  logic [4:0] count;

  // Count unread non-empty cycles; fire on the cycle after the last allowed one and restart.
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= 1'b0;
      if (read_enb || fifo_empty) begin
        count <= '0;
      end else if (count == LAST) begin
        count      <= '0;
        soft_reset <= 1'b1;
      end else begin
        count <= count + 5'd1;
      end
    end
  end

endmodule

// File: rtl/router_pkt_ctrl.sv
// Ingress packet controller for the 1x3 router: decodes the header address,
// sequences header/payload/parity writes into the addressed FIFO, checks parity
// and watches each FIFO for a stalled destination.
module router_pkt_ctrl #(
  parameter int TIMEOUT = router_pkg::TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic [7:0] dout,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset,
  output logic       parity_done,
  output logic       err
);

  import router_pkg::*;

  state_t     state;
  logic [7:0] hdr;
  logic [7:0] int_parity;
  logic [7:0] ext_parity;
  logic [1:0] addr;
  logic       port_full;
  logic       port_empty;
  logic       port_sreset;
  logic [2:0] port_sel;

  assign addr        = hdr[1:0];
  assign port_full   = bit_at(fifo_full, addr);
  assign port_empty  = bit_at(fifo_empty, addr);
  assign port_sreset = bit_at(soft_reset, addr);
  assign port_sel    = port_onehot(addr);
  assign vld_out     = ~fifo_empty;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
    router_sreset_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock      (clock),
      .reset      (reset),
      .read_enb   (read_enb[i]),
      .fifo_empty (fifo_empty[i]),
      .soft_reset (soft_reset[i])
    );
  end

  // Packet sequencer: state, latched header, running and received parity, error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= DA;
      hdr         <= '0;
      int_parity  <= '0;
      ext_parity  <= '0;
      err         <= 1'b0;
      parity_done <= 1'b0;
    end else begin
      parity_done <= 1'b0;
      case (state)
        DA: begin
          if (pkt_valid) begin
            hdr        <= data_in;
            int_parity <= data_in;
            err        <= 1'b0;
            if (data_in[1:0] == ADDR_INVALID)
              state <= DROP;
            else if (bit_at(fifo_empty, data_in[1:0]))
              state <= LFD;
            else
              state <= WTE;
          end
        end
        WTE: begin
          if (port_empty)
            state <= LFD;
        end
        LFD: begin
          state <= port_sreset ? DROP : LD;
        end
        LD: begin
          if (port_sreset)
            state <= DROP;
          else if (!pkt_valid)
            state <= LP;
          else if (!port_full)
            int_parity <= int_parity ^ data_in;
        end
        LP: begin
          if (port_sreset) begin
            state <= DA;
          end else if (!port_full) begin
            ext_parity  <= data_in;
            parity_done <= 1'b1;
            state       <= CPE;
          end
        end
        CPE: begin
          err   <= (int_parity != ext_parity);
          state <= DA;
        end
        DROP: begin
          if (!pkt_valid)
            state <= DA;
        end
        default: state <= DA;
      endcase
    end
  end

  // Source handshake and FIFO write controls decoded from the current state.
  always_comb begin
    busy      = 1'b0;
    write_enb = 3'b000;
    lfd_state = 1'b0;
    dout      = data_in;
    case (state)
      WTE: busy = 1'b1;
      LFD: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        dout      = hdr;
        write_enb = port_sel;
      end
      LD: begin
        busy = port_full;
        if (pkt_valid && !port_full)
          write_enb = port_sel;
      end
      LP: begin
        busy = port_full;
        if (!port_full)
          write_enb = port_sel;
      end
      CPE: busy = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Self-checking bench for router_pkt_ctrl: directed packets from the test plan,
// timeout pulses, then randomized packets checked against a transaction-level model.
module tb_router_pkt_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       busy;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic [7:0] dout;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       err;

  int checkCount = 0;
  int errorCount = 0;
  int parityDoneCount = 0;
  logic [8:0] writeLog [3][$];

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  router_pkt_ctrl #(.TIMEOUT(30)) dut (
    .clock       (clock),
    .reset       (reset),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .read_enb    (read_enb),
    .busy        (busy),
    .write_enb   (write_enb),
    .lfd_state   (lfd_state),
    .dout        (dout),
    .vld_out     (vld_out),
    .soft_reset  (soft_reset),
    .parity_done (parity_done),
    .err         (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Record every FIFO write as {lfd_state, dout} and sanity-check write strobes each cycle.
  always @(negedge clock) begin
    if (!reset) begin
      for (int p = 0; p < 3; p++)
        if (write_enb[p]) writeLog[p].push_back({lfd_state, dout});
      if (write_enb != 3'b000) checkOutput("we_onehot", 32'($onehot(write_enb)), 1);
      if (lfd_state) checkOutput("lfd_needs_write", 32'(write_enb != 3'b000), 1);
      if (parity_done) parityDoneCount++;
    end
  end

  // Present one byte and hold it until the controller accepts it (busy low at an edge).
  task automatic applyStimulus(input logic [7:0] d, input logic v);
    int guard = 0;
    data_in = d;
    pkt_valid = v;
    #1;
    while (busy && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    if (guard >= 200) checkOutput("accept_timeout", guard, 0);
    @(posedge clock); #1;
  endtask

  task automatic runPacket(input logic [1:0] addr, input int len, input bit corrupt,
                           input int waitCycles, input int stallAt, input int stallLen);
    logic [7:0] hdr;
    logic [7:0] par;
    logic [7:0] sentPar;
    logic [7:0] payload[$];
    logic [8:0] expected[$];
    int expN;
    hdr = {6'(len), addr};
    par = hdr;
    for (int i = 0; i < len; i++) begin
      payload.push_back(8'($urandom));
      par = par ^ payload[i];
    end
    sentPar = corrupt ? (par ^ 8'h01) : par;
    expected.push_back({1'b1, hdr});
    foreach (payload[i]) expected.push_back({1'b0, payload[i]});
    expected.push_back({1'b0, sentPar});
    for (int p = 0; p < 3; p++) writeLog[p].delete();
    parityDoneCount = 0;

    if (waitCycles > 0 && addr != 2'd3) fifo_empty[addr] = 1'b0;
    applyStimulus(hdr, 1'b1);
    checkOutput("err_clr_on_hdr", 32'(err), 0);

    if (waitCycles > 0 && addr != 2'd3) begin
      data_in = payload[0];
      pkt_valid = 1'b1;
      for (int c = 0; c < waitCycles; c++) begin
        #1;
        checkOutput("wte_busy", 32'(busy), 1);
        checkOutput("wte_no_write", 32'(write_enb), 0);
        checkOutput("wte_vld", 32'(vld_out[addr]), 1);
        @(posedge clock); #1;
      end
      fifo_empty[addr] = 1'b1;
    end

    for (int i = 0; i < len; i++) begin
      if (i == stallAt && i > 0 && stallLen > 0 && addr != 2'd3) begin
        data_in = payload[i];
        pkt_valid = 1'b1;
        fifo_full[addr] = 1'b1;
        for (int c = 0; c < stallLen; c++) begin
          #1;
          checkOutput("stall_busy", 32'(busy), 1);
          checkOutput("stall_no_write", 32'(write_enb), 0);
          @(posedge clock); #1;
        end
        fifo_full[addr] = 1'b0;
      end
      applyStimulus(payload[i], 1'b1);
    end

    data_in = sentPar;
    pkt_valid = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
    end

    for (int p = 0; p < 3; p++) begin
      expN = (p == int'(addr)) ? expected.size() : 0;
      checkOutput($sformatf("wr_count_p%0d", p), writeLog[p].size(), expN);
      if (p == int'(addr))
        for (int i = 0; i < expected.size() && i < writeLog[p].size(); i++)
          checkOutput($sformatf("wr_byte_p%0d_%0d", p, i), 32'(writeLog[p][i]), 32'(expected[i]));
    end
    checkOutput("parity_done_cnt", parityDoneCount, (addr != 2'd3) ? 1 : 0);
    checkOutput("err_after_pkt", 32'(err), (addr != 2'd3 && corrupt) ? 1 : 0);
    checkOutput("idle_busy", 32'(busy), 0);
  endtask

  // Leave FIFO 2 non-empty and unread; optionally read once before edge readAt.
  task automatic timerTest(input int readAt, input int expectEdge);
    int edges = 0;
    bit seen = 1'b0;
    fifo_empty[2] = 1'b0;
    read_enb = 3'b000;
    while (!seen && edges < 100) begin
      read_enb[2] = (edges + 1 == readAt);
      @(posedge clock); #1;
      edges++;
      if (soft_reset != 3'b000) seen = 1'b1;
    end
    checkOutput($sformatf("sreset_edge_r%0d", readAt), edges, expectEdge);
    checkOutput("sreset_which", 32'(soft_reset), 32'b100);
    read_enb = 3'b000;
    @(posedge clock); #1;
    checkOutput("sreset_one_cycle", 32'(soft_reset), 0);
    fifo_empty[2] = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    int addr, len, waitC, stallAt, stallLen;
    reset = 1'b1;
    pkt_valid = 1'b0;
    data_in = 8'h00;
    fifo_full = 3'b000;
    fifo_empty = 3'b110;
    read_enb = 3'b000;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_write_enb", 32'(write_enb), 0);
    checkOutput("rst_lfd", 32'(lfd_state), 0);
    checkOutput("rst_soft_reset", 32'(soft_reset), 0);
    checkOutput("rst_parity_done", 32'(parity_done), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_vld_out", 32'(vld_out), 32'b001);
    fifo_empty = 3'b111;
    reset = 1'b0;
    @(posedge clock); #1;

    runPacket(2'd1, 12, 1'b0, 0, 0, 0);
    runPacket(2'd1, 12, 1'b1, 0, 0, 0);
    runPacket(2'd0, 7, 1'b0, 6, 0, 0);
    runPacket(2'd1, 12, 1'b0, 0, 5, 4);
    runPacket(2'd3, 5, 1'b0, 0, 0, 0);
    timerTest(0, 30);
    timerTest(20, 50);

    for (int n = 0; n < 40; n++) begin
      addr = $urandom_range(0, 3);
      len = $urandom_range(0, 20);
      waitC = (len > 0 && addr != 3 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      stallAt = (len > 1) ? $urandom_range(1, len - 1) : 0;
      stallLen = $urandom_range(0, 4);
      runPacket(2'(addr), len, 1'($urandom_range(0, 1)), waitC, stallAt, stallLen);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    errorCount++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
